// File: rtl/add_shift_mult_ctrl.sv
`timescale 1ns/1ps
// Shift-and-add sequencer for unsigned WIDTH x WIDTH -> 2*WIDTH multiplication,
// driving the shared external ripple adder for one pass per clock.
module add_shift_mult_ctrl #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   output logic                 busy,
   output logic                 done,
   output logic [2*WIDTH-1:0]   product,
   output logic [WIDTH-1:0]     add_a,
   output logic [WIDTH-1:0]     add_b,
   output logic                 add_cin,
   input  logic [WIDTH-1:0]     add_sum,
   input  logic                 add_cout
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t            state;
   state_t            next_state;
   logic [WIDTH-1:0]  mcand;
   logic [WIDTH-1:0]  acc_hi;
   logic [WIDTH-1:0]  acc_lo;
   logic [CNT_W-1:0]  cnt;
   logic              last_iter;

   assign last_iter = (cnt == CNT_W'(WIDTH - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (start) next_state = RUN;
         RUN:     if (last_iter) next_state = DONE;
         DONE:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Each RUN cycle shifts the adder result right by one across {acc_hi, acc_lo};
   // the carry lands in the top bit, so the 2*WIDTH result never overflows.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mcand   <= '0;
         acc_hi  <= '0;
         acc_lo  <= '0;
         cnt     <= '0;
         product <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  mcand  <= a;
                  acc_hi <= '0;
                  acc_lo <= b;
                  cnt    <= '0;
               end
            end
            RUN: begin
               acc_hi <= {add_cout, add_sum[WIDTH-1:1]};
               acc_lo <= {add_sum[0], acc_lo[WIDTH-1:1]};
               cnt    <= cnt + CNT_W'(1);
            end
            DONE:    product <= {acc_hi, acc_lo};
            default: ;
         endcase
      end
   end

   always_comb begin
      busy    = (state != IDLE);
      done    = (state == DONE);
      add_a   = acc_hi;
      add_b   = acc_lo[0] ? mcand : '0;
      add_cin = 1'b0;
   end

endmodule

// File: tb/tb_add_shift_mult_ctrl.sv
`timescale 1ns/1ps
// Directed bench for add_shift_mult_ctrl with a behavioural model of the external
// 32-bit adder; expected products are hand-computed or from a 64-bit reference multiply.
module tb_add_shift_mult_ctrl;

   localparam int WIDTH = 32;

   logic               clk;
   logic               rst_n;
   logic               start;
   logic [WIDTH-1:0]   a;
   logic [WIDTH-1:0]   b;
   logic               busy;
   logic               done;
   logic [2*WIDTH-1:0] product;
   logic [WIDTH-1:0]   add_a;
   logic [WIDTH-1:0]   add_b;
   logic               add_cin;
   logic [WIDTH-1:0]   add_sum;
   logic               add_cout;

   int tests_run;
   int tests_failed;

   add_shift_mult_ctrl #(.WIDTH(WIDTH), .CNT_W(6)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
      .busy(busy), .done(done), .product(product),
      .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
      .add_sum(add_sum), .add_cout(add_cout)
   );

   // Stand-in for the external ripple adder
   assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {{WIDTH{1'b0}}, add_cin};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Entered at the negedge of cycle 1 after the start edge; returns in the first IDLE cycle
   task automatic track_op(output int done_cyc, output int busy_cyc, output int pulses);
      done_cyc = -1;
      busy_cyc = 0;
      pulses   = 0;
      for (int cyc = 1; cyc <= 60; cyc++) begin
         if (busy) busy_cyc++;
         if (done) begin
            pulses++;
            if (done_cyc < 0) done_cyc = cyc;
         end
         if (!busy) break;
         @(negedge clk);
      end
   endtask

   task automatic run_op(input logic [31:0] ia, input logic [31:0] ib, output logic [63:0] prod,
                         output int done_cyc, output int busy_cyc, output int pulses);
      @(negedge clk);
      start = 1'b1; a = ia; b = ib;
      @(negedge clk);
      start = 1'b0; a = $urandom; b = $urandom;
      track_op(done_cyc, busy_cyc, pulses);
      prod = product;
   endtask

   task automatic test_reset;
      rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
      repeat (2) @(negedge clk);
      tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
      tests_run++; if (done !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
      tests_run++; if (product !== 64'h0) begin tests_failed++; $display("[TB] FAIL reset_product: got %h expected 0", product); end
      tests_run++; if (add_a !== 32'h0) begin tests_failed++; $display("[TB] FAIL reset_add_a: got %h expected 0", add_a); end
      tests_run++; if (add_b !== 32'h0) begin tests_failed++; $display("[TB] FAIL reset_add_b: got %h expected 0", add_b); end
      tests_run++; if (add_cin !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_add_cin: got %b expected 0", add_cin); end
      rst_n = 1'b1;
   endtask

   task automatic test_max_operands;
      logic [63:0] prod;
      int          dc, bc, pc;
      run_op(32'hFFFFFFFF, 32'hFFFFFFFF, prod, dc, bc, pc);
      tests_run++; if (dc !== 33) begin tests_failed++; $display("[TB] FAIL max_done_latency: got %0d expected 33", dc); end
      tests_run++; if (pc !== 1) begin tests_failed++; $display("[TB] FAIL max_done_pulses: got %0d expected 1", pc); end
      tests_run++; if (bc !== 33) begin tests_failed++; $display("[TB] FAIL max_busy_cycles: got %0d expected 33", bc); end
      tests_run++; if (prod !== 64'hFFFFFFFE00000001) begin tests_failed++; $display("[TB] FAIL max_product: got %h expected fffffffe00000001", prod); end
   endtask

   task automatic test_zero_and_one;
      logic [63:0] prod;
      int          dc, bc, pc;
      run_op(32'h00000000, 32'h12345678, prod, dc, bc, pc);
      tests_run++; if (prod !== 64'h0) begin tests_failed++; $display("[TB] FAIL zero_product: got %h expected 0", prod); end
      run_op(32'h00000001, 32'hFFFFFFFF, prod, dc, bc, pc);
      tests_run++; if (prod !== 64'h00000000FFFFFFFF) begin tests_failed++; $display("[TB] FAIL one_product: got %h expected 00000000ffffffff", prod); end
   endtask

   // Watches the adder operands every RUN cycle: acc_lo[0] in iteration i is bit i of b
   task automatic test_adder_drive;
      logic [31:0] ma, mb, hi, exp_b;
      logic [32:0] s;
      ma = 32'h0000FFFF; mb = 32'h00010001; hi = '0;
      @(negedge clk);
      start = 1'b1; a = ma; b = mb;
      @(negedge clk);
      start = 1'b0; a = '0; b = '0;
      for (int i = 0; i < 32; i++) begin
         exp_b = mb[i] ? ma : 32'h0;
         tests_run++; if (add_cin !== 1'b0) begin tests_failed++; $display("[TB] FAIL drive_add_cin[%0d]: got %b expected 0", i, add_cin); end
         tests_run++; if (add_b !== exp_b) begin tests_failed++; $display("[TB] FAIL drive_add_b[%0d]: got %h expected %h", i, add_b, exp_b); end
         tests_run++; if (add_a !== hi) begin tests_failed++; $display("[TB] FAIL drive_add_a[%0d]: got %h expected %h", i, add_a, hi); end
         s  = {1'b0, hi} + {1'b0, exp_b};
         hi = s[32:1];
         @(negedge clk);
      end
      tests_run++; if (done !== 1'b1) begin tests_failed++; $display("[TB] FAIL drive_done: got %b expected 1", done); end
      @(negedge clk);
      tests_run++; if (product !== 64'h00000000FFFFFFFF) begin tests_failed++; $display("[TB] FAIL drive_product: got %h expected 00000000ffffffff", product); end
      tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL drive_idle: got %b expected 0", busy); end
   endtask

   task automatic test_back_to_back;
      int dc, bc, pc;
      @(negedge clk);
      start = 1'b1; a = 32'd3; b = 32'd5;
      @(negedge clk);
      a = 32'd7; b = 32'd7;
      dc = -1;
      for (int cyc = 1; cyc <= 60; cyc++) begin
         if (cyc == 20) start = 1'b0;
         if (done) begin dc = cyc; break; end
         @(negedge clk);
      end
      tests_run++; if (dc !== 33) begin tests_failed++; $display("[TB] FAIL held_start_latency: got %0d expected 33", dc); end
      start = 1'b1; a = 32'd7; b = 32'd7;
      @(negedge clk);
      tests_run++; if (done !== 1'b0) begin tests_failed++; $display("[TB] FAIL held_start_single_pulse: got %b expected 0", done); end
      tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL held_start_idle: got %b expected 0", busy); end
      tests_run++; if (product !== 64'd15) begin tests_failed++; $display("[TB] FAIL held_start_product: got %0d expected 15", product); end
      @(negedge clk);
      start = 1'b0;
      tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("[TB] FAIL b2b_accepted: got %b expected 1", busy); end
      track_op(dc, bc, pc);
      tests_run++; if (pc !== 1) begin tests_failed++; $display("[TB] FAIL b2b_pulses: got %0d expected 1", pc); end
      tests_run++; if (bc !== 33) begin tests_failed++; $display("[TB] FAIL b2b_busy_cycles: got %0d expected 33", bc); end
      tests_run++; if (product !== 64'd49) begin tests_failed++; $display("[TB] FAIL b2b_product: got %0d expected 49", product); end
   endtask

   task automatic test_async_reset;
      logic [63:0] prod;
      int          dc, bc, pc, seen_done;
      @(negedge clk);
      start = 1'b1; a = 32'hFFFFFFFF; b = 32'd2;
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      #1 rst_n = 1'b0;
      #0.5;
      tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL areset_busy: got %b expected 0", busy); end
      tests_run++; if (done !== 1'b0) begin tests_failed++; $display("[TB] FAIL areset_done: got %b expected 0", done); end
      tests_run++; if (product !== 64'h0) begin tests_failed++; $display("[TB] FAIL areset_product: got %h expected 0", product); end
      tests_run++; if (add_a !== 32'h0) begin tests_failed++; $display("[TB] FAIL areset_add_a: got %h expected 0", add_a); end
      #0.5 rst_n = 1'b1;
      seen_done = 0;
      for (int cyc = 0; cyc < 40; cyc++) begin
         @(negedge clk);
         if (done || busy) seen_done++;
      end
      tests_run++; if (seen_done !== 0) begin tests_failed++; $display("[TB] FAIL areset_discarded: got %0d active cycles expected 0", seen_done); end
      run_op(32'd6, 32'd7, prod, dc, bc, pc);
      tests_run++; if (prod !== 64'd42) begin tests_failed++; $display("[TB] FAIL areset_recover: got %0d expected 42", prod); end
   endtask

   task automatic test_random;
      logic [31:0] ra, rb;
      logic [63:0] prod, expd;
      int          dc, bc, pc;
      for (int i = 0; i < 1000; i++) begin
         if (i == 0) begin
            ra = 32'h80000000; rb = 32'h80000000; expd = 64'h4000000000000000;
         end else begin
            ra = $urandom; rb = $urandom;
            if (i % 50 == 1) rb = 32'hFFFFFFFF;
            expd = {32'h0, ra} * {32'h0, rb};
         end
         run_op(ra, rb, prod, dc, bc, pc);
         tests_run++; if (prod !== expd) begin tests_failed++; $display("[TB] FAIL rand_product[%0d]: %h*%h got %h expected %h", i, ra, rb, prod, expd); end
         tests_run++; if (bc !== 33) begin tests_failed++; $display("[TB] FAIL rand_busy_cycles[%0d]: got %0d expected 33", i, bc); end
      end
   endtask

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      test_reset();
      test_max_operands();
      test_zero_and_one();
      test_adder_drive();
      test_back_to_back();
      test_async_reset();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
